// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
package dmem_responder_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between a CPU data port and the responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage: synchronous write, combinational read; contents are never reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Serialized word responder: accepts one request, waits LATENCY cycles, then
// holds a read-data or write-acknowledge response until the requester takes it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // WAIT spans LATENCY+1 cycles; the final one, at count zero, is the access cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be within 1..15");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("dmem_responder: DEPTH_WORDS must be a power of two, at least 4");
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               write_reg;
  logic [WORD_W-1:0]  addr_reg;
  logic [WORD_W-1:0]  wdata_reg;
  logic [WORD_W-1:0]  rdata_reg, rdata_next;
  logic               err_reg, err_next;

  logic               accept;
  logic [WORD_W:0]    offset;
  logic               addr_err;
  logic [IDX_W-1:0]   word_idx;
  logic               mem_we;
  logic [WORD_W-1:0]  mem_rdata;

  assign accept = bus.req_valid && (state_reg == IDLE);

  // 33-bit offset: a borrow (addr below base) or any bit above the index is out of range.
  assign offset   = {1'b0, addr_reg} - {1'b0, BASE_ADDR};
  assign addr_err = (|offset[BYTE_OFF_W-1:0]) || (|offset[WORD_W:IDX_W+BYTE_OFF_W]);
  assign word_idx = offset[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clock (clock),
    .we    (mem_we && !reset),
    .widx  (word_idx),
    .wdata (wdata_reg),
    .ridx  (word_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      if (accept) begin
        write_reg <= bus.req_write;
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
          mem_we     = write_reg && !addr_err;
          err_next   = addr_err;
          rdata_next = (write_reg || addr_err) ? '0 : mem_rdata;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next = IDLE;
          rdata_next = '0;
          err_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_rdata = rdata_reg;
  assign bus.resp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 4, 1) driven one transaction at a time.
module tb_dmem_responder;

  typedef struct {
    int          k;
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int          cycle = 0;
  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  bit          lat_seen [3];

  logic        req_valid  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_ready [3];
  logic        rdy [3];
  logic        rv  [3];
  logic [31:0] rd  [3];
  logic        re  [3];

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : 1;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    dmem_responder_if bus ();
    assign bus.req_valid  = req_valid[gi];
    assign bus.req_write  = req_write[gi];
    assign bus.req_addr   = req_addr[gi];
    assign bus.req_wdata  = req_wdata[gi];
    assign bus.resp_ready = resp_ready[gi];
    assign rdy[gi] = bus.req_ready;
    assign rv[gi]  = bus.resp_valid;
    assign rd[gi]  = bus.resp_rdata;
    assign re[gi]  = bus.resp_err;

    dmem_responder #(
      .DEPTH_WORDS (256),
      .LATENCY     ((gi == 0) ? 2 : (gi == 1) ? 4 : 1),
      .BASE_ADDR   (32'h0000_0000)
    ) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );
  end

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d actual=%h required=%h", name, k, act, exp);
    end else begin
      $display("ok   %s dut=%0d value=%h", name, k, act);
    end
  endtask

  // Monitor: every cycle a response is presented it must match the queue head.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (rv[k] === 1'b1) begin
        if (sb.size() == 0 || sb[0].k != k) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp dut=%0d actual=valid required=no response", k);
        end else begin
          if (!lat_seen[k]) begin
            chk("latency", k, 32'(cycle - sb[0].acc), 32'(lat_of(k) + 1));
            lat_seen[k] = 1'b1;
          end
          chk("resp_err", k, {31'd0, re[k]}, {31'd0, sb[0].err});
          chk("resp_rdata", k, rd[k], sb[0].rdata);
          if (resp_ready[k]) begin
            void'(sb.pop_front());
            lat_seen[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(int k, bit wr, logic [31:0] a, logic [31:0] wd,
                       bit eerr, logic [31:0] erd, bit push);
    int n = 0;
    @(negedge clock);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    while (rdy[k] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (rdy[k] !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout dut=%0d actual=not ready required=ready", k);
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    if (push) sb.push_back('{k: k, err: eerr, rdata: erd, acc: cycle});
    // Scramble inputs after acceptance; the latched request must be used.
    req_valid[k] = 1'b0;
    req_write[k] = ~wr;
    req_addr[k]  = 32'h0000_0013;
    req_wdata[k] = 32'hFFFF_FFFF;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL resp_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid(int k);
    int n = 0;
    while (rv[k] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (rv[k] !== 1'b1) begin
      bad++;
      $display("FAIL valid_timeout dut=%0d actual=%b required=1", k, rv[k]);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; resp_ready[k] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", k, {31'd0, rdy[k]}, 32'd1);
      chk("rst_resp_valid", k, {31'd0, rv[k]}, 32'd0);
      chk("rst_resp_rdata", k, rd[k], 32'd0);
      chk("rst_resp_err", k, {31'd0, re[k]}, 32'd0);
    end

    // LATENCY=2: store/load, errors, aliasing, last word, wrap boundary
    issue(0, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0, 1'b1); drain();
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1); drain();
    issue(0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1); drain();
    issue(0, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0, 1'b1); drain();
    issue(0, 1'b1, 32'h0000_0400, 32'hBAD0_BAD0, 1'b1, 32'h0, 1'b1); drain();
    issue(0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678, 1'b1); drain();
    issue(0, 1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 1'b0, 32'h0, 1'b1); drain();
    issue(0, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hA5A5_5A5A, 1'b1); drain();
    issue(0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0, 1'b1); drain();

    // Backpressure: response held 5 cycles while a stray request is offered
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = 1'b1; req_write[0] = 1'b1;
      req_addr[0] = 32'h0000_0000; req_wdata[0] = 32'h5555_AAAA;
      @(negedge clock);
      chk("bp_req_ready", 0, {31'd0, rdy[0]}, 32'd0);
      chk("bp_resp_valid", 0, {31'd0, rv[0]}, 32'd1);
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    @(negedge clock);
    chk("bp_idle_ready", 0, {31'd0, rdy[0]}, 32'd1);
    chk("bp_idle_valid", 0, {31'd0, rv[0]}, 32'd0);
    chk("bp_idle_rdata", 0, rd[0], 32'd0);
    drain();
    issue(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h1234_5678, 1'b1); drain();

    // LATENCY=4: reset one cycle after accepting a store abandons it
    issue(1, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h0, 1'b1); drain();
    issue(1, 1'b1, 32'h0000_0020, 32'hCAFE_0001, 1'b0, 32'h0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_req_ready", 1, {31'd0, rdy[1]}, 32'd1);
    chk("midrst_resp_valid", 1, {31'd0, rv[1]}, 32'd0);
    chk("midrst_resp_rdata", 1, rd[1], 32'd0);
    chk("midrst_resp_err", 1, {31'd0, re[1]}, 32'd0);
    repeat (8) @(negedge clock);
    issue(1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0000_0000, 1'b1); drain();

    // LATENCY=1: minimum wait, response two cycles after acceptance
    issue(2, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b1); drain();
    issue(2, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b1); drain();

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
